axi4lite_master: RTL

AXI4LITE_MASTER -- requirements
Module: axi4lite_master

---
 rtl/axi4lite_master.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one local command into one AXI
// read or write transaction and returns the captured response.
module axi4lite_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    // local command / response
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // write address / data / response
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // read address / data
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    // current FSM state for observation
    output logic [2:0]            dbg_state
);

    // Handshakes everywhere are strict valid/ready: a transfer happens on a
    // rising edge where both are high; a raised valid, and the payload it
    // qualifies, stay put until that edge.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cmd_hs, rsp_hs;

    assign aw_hs  = awvalid_q && m_axi_awready;
    assign w_hs   = wvalid_q && m_axi_wready;
    assign b_hs   = m_axi_bvalid && bready_q;
    assign ar_hs  = arvalid_q && m_axi_arready;
    assign r_hs   = m_axi_rvalid && rready_q;
    assign cmd_hs = cmd_valid && cmd_ready_q;
    assign rsp_hs = rsp_valid_q && rsp_ready;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    // Every output is a register, so the next value of each is decided here
    // together with the next state.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        unique case (state_q)
            S_IDLE: begin
                // cmd_ready also comes up here on the first cycle after reset
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    cmd_ready_d = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (cmd_write) begin
                        state_d   = S_WR;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently, in either order
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign dbg_state     = state_q;

endmodule
